ifu_prefetch: RTL and testbench

IFU_PREFETCH -- requirements
Module: ifu_prefetch

---
 rtl/ifu_prefetch.sv | 160 ++++++++++++++++
 tb/tb_ifu_prefetch.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit prefetcher.
// Fetches one instruction at a time from memory into a small FIFO.
// The decode stage drains that FIFO. A redirect flushes the FIFO and restarts fetching.
// Optional feature: define IFU_PREFETCH_PERF_EN to add the fetch_cnt/stall_cnt counters.
//
// Handshakes: a transfer happens on any rising clk edge where valid and ready are both 1.
// A valid, once raised, keeps its payload stable until that transfer, unless a redirect
// withdraws it. resp_valid has no ready: the unit accepts every response.
module ifu_prefetch #(
   parameter int              AW       = 32,
   parameter int              IW       = 32,
   parameter int              DEPTH    = 4,
   parameter logic [AW-1:0]   RESET_PC = 32'h8000_0000
) (
   input  logic          clk,
   input  logic          rst,
   output logic          req_valid,
   input  logic          req_ready,
   output logic [AW-1:0] req_addr,
   input  logic          resp_valid,
   input  logic [IW-1:0] resp_data,
   input  logic          resp_err,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [IW-1:0] inst,
   output logic [AW-1:0] inst_pc,
   output logic          inst_err,
`ifdef IFU_PREFETCH_PERF_EN
   output logic [31:0]   fetch_cnt,
   output logic [31:0]   stall_cnt,
`endif
   output logic [1:0]    dbg_state
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t        state;
   logic [AW-1:0] pc;
   // A response is still in flight from before a reset. Drop it before issuing new requests.
   logic          drop_pend;

   logic [IW-1:0] buf_data [DEPTH];
   logic [AW-1:0] buf_pc   [DEPTH];
   logic          buf_err  [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          empty;
   logic          push;
   logic          pop;

   assign empty      = (count == '0);
   assign inst_valid = !empty;
   assign pop        = inst_valid && inst_ready;
   // Redirect takes priority over enqueue. A response that coincides with a redirect is discarded.
   assign push       = !rst && (state == WAIT) && resp_valid && !redirect_valid;

   assign req_addr   = pc;
   assign inst       = empty ? '0 : buf_data[head];
   assign inst_pc    = empty ? '0 : buf_pc[head];
   assign inst_err   = empty ? 1'b0 : buf_err[head];
   assign dbg_state  = state;

   // Fetch FSM: holds the fetch pc, issues requests, and tracks the single outstanding response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_valid <= 1'b0;
         pc        <= RESET_PC;
         drop_pend <= ((state == WAIT) || (state == DROP) || drop_pend) && !resp_valid;
      end else begin
         case (state)
            IDLE: begin
               if (redirect_valid) pc <= redirect_pc;
               if (drop_pend) begin
                  if (resp_valid) drop_pend <= 1'b0;
               end else if (!redirect_valid && (count < CW'(DEPTH))) begin
                  state     <= REQ;
                  req_valid <= 1'b1;
               end
            end
            REQ: begin
               if (req_ready) begin
                  // The accepted request must still be answered. Under a redirect, drop its answer.
                  state     <= redirect_valid ? DROP : WAIT;
                  req_valid <= 1'b0;
                  if (redirect_valid) pc <= redirect_pc;
               end else if (redirect_valid) begin
                  state     <= IDLE;
                  req_valid <= 1'b0;
                  pc        <= redirect_pc;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  pc    <= redirect_pc;
                  state <= resp_valid ? IDLE : DROP;
               end else if (resp_valid) begin
                  pc    <= pc + AW'(4);
                  state <= IDLE;
               end
            end
            DROP: begin
               if (redirect_valid) pc <= redirect_pc;
               if (resp_valid) state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               req_valid <= 1'b0;
            end
         endcase
      end
   end

   // Buffer pointers and occupancy. A redirect flushes the buffer, even when a pop happens in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Buffer storage. Entries are only read while counted as occupied.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[tail] <= resp_data;
         buf_pc[tail]   <= pc;
         buf_err[tail]  <= resp_err;
      end
   end

`ifdef IFU_PREFETCH_PERF_EN
   // Performance counters: count enqueued instructions, and cycles where decode starved.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (push) fetch_cnt <= fetch_cnt + 32'd1;
         if (inst_ready && !inst_valid) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Testbench for ifu_prefetch.
// The bench models memory itself and keeps a transaction-level reference model.
// It checks the DUT against that model every cycle, and runs directed scenarios plus random traffic.
module tb_ifu_prefetch;

   localparam int            AW       = 32;
   localparam int            IW       = 32;
   localparam int            DEPTH    = 4;
   localparam logic [AW-1:0] RESET_PC = 32'h8000_0000;
   localparam int            EW       = 1 + AW + IW;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic          resp_valid;
   logic [IW-1:0] resp_data;
   logic          resp_err;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          inst_valid;
   logic          inst_ready;
   logic [IW-1:0] inst;
   logic [AW-1:0] inst_pc;
   logic          inst_err;
   logic [1:0]    dbg_state;
`ifdef IFU_PREFETCH_PERF_EN
   logic [31:0]   fetch_cnt;
   logic [31:0]   stall_cnt;
`endif

   ifu_prefetch #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .inst_err(inst_err),
`ifdef IFU_PREFETCH_PERF_EN
      .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / model state ----------------
   int            checks = 0;
   int            errors = 0;
   logic [EW-1:0] exp_q[$];     // expected buffer contents {err, pc, data}
   logic [AW:0]   out_q[$];     // outstanding requests {stale, addr}
   logic [AW-1:0] fire_log[$];  // addresses of accepted requests
   logic [EW-1:0] pop_log[$];   // entries consumed by decode
   logic [AW-1:0] mpc;
   logic [31:0]   m_fetch;
   logic [31:0]   m_stall;
   int            mem_timer;
   int            lat_min, lat_max;
   logic          err_by_addr;
   logic [AW-1:0] err_addr;
   int            rdy_pct, inst_pct, redir_pct;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Memory response driver: the answer arrives once the latency timer expires. It is held off during reset.
   task automatic drive_mem();
      if (!rst && out_q.size() != 0 && mem_timer == 0) begin
         resp_valid = 1'b1;
         resp_data  = $urandom;
         resp_err   = err_by_addr ? (out_q[0][AW-1:0] == err_addr) : ($urandom_range(7, 0) == 0);
      end else begin
         resp_valid = 1'b0;
         resp_data  = '0;
         resp_err   = 1'b0;
      end
   endtask

   // One clock cycle. At the falling edge: compare the DUT with the model, then advance the model
   // by what the rising edge will do. After the rising edge: drive the next inputs.
   task automatic tick();
      logic          fire;
      logic          popv;
      logic [AW-1:0] cur_pc;
      logic [EW-1:0] e;
      logic [AW:0]   o;
      @(negedge clk);
      if (rst) begin
         exp_q.delete();
         mpc     = RESET_PC;
         m_fetch = '0;
         m_stall = '0;
         foreach (out_q[i]) out_q[i][AW] = 1'b1;
         if (mem_timer > 0) mem_timer--;
      end else begin
         cur_pc = mpc;
         check("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
         if (inst_valid && exp_q.size() != 0) begin
            e = exp_q[0];
            check("inst", 64'(inst), 64'(e[IW-1:0]));
            check("inst_pc", 64'(inst_pc), 64'(e[IW+AW-1:IW]));
            check("inst_err", 64'(inst_err), 64'(e[EW-1]));
         end
         if (req_valid) check("req_addr", 64'(req_addr), 64'(cur_pc));
         if (out_q.size() != 0 || exp_q.size() >= DEPTH) check("req_blocked", 64'(req_valid), 64'd0);
`ifdef IFU_PREFETCH_PERF_EN
         check("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
         check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
         fire = req_valid && req_ready;
         popv = inst_valid && inst_ready;
         if (inst_ready && exp_q.size() == 0) m_stall++;
         if (popv && exp_q.size() != 0) pop_log.push_back(exp_q.pop_front());
         if (resp_valid && out_q.size() != 0) begin
            o = out_q.pop_front();
            if (!o[AW] && !redirect_valid) begin
               exp_q.push_back({resp_err, o[AW-1:0], resp_data});
               m_fetch++;
               mpc = o[AW-1:0] + 32'd4;
            end
         end
         if (redirect_valid) begin
            exp_q.delete();
            mpc = redirect_pc;
            foreach (out_q[i]) out_q[i][AW] = 1'b1;
         end
         if (fire) begin
            out_q.push_back({redirect_valid, cur_pc});
            fire_log.push_back(cur_pc);
            mem_timer = $urandom_range(lat_max, lat_min);
         end else if (mem_timer > 0) begin
            mem_timer--;
         end
      end
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      drive_mem();
   endtask

   task automatic apply_reset(input int n);
      rst            = 1'b1;
      req_ready      = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      drive_mem();
      repeat (n) tick();
      check("rst_req_valid", 64'(req_valid), 64'd0);
      check("rst_inst_valid", 64'(inst_valid), 64'd0);
      check("rst_req_addr", 64'(req_addr), 64'(RESET_PC));
      check("rst_inst", 64'(inst), 64'd0);
      check("rst_inst_pc", 64'(inst_pc), 64'd0);
      check("rst_inst_err", 64'(inst_err), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
`ifdef IFU_PREFETCH_PERF_EN
      check("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      rst = 1'b0;
      drive_mem();
      fire_log.delete();
      pop_log.delete();
   endtask

   task automatic drive_random();
      req_ready  = ($urandom_range(99, 0) < rdy_pct);
      inst_ready = ($urandom_range(99, 0) < inst_pct);
      if ($urandom_range(99, 0) < redir_pct) begin
         redirect_valid = 1'b1;
         redirect_pc    = $urandom;
      end
   endtask

   task automatic run_until_outstanding(input int bound);
      for (int i = 0; i < bound && out_q.size() == 0; i++) tick();
      check("reach_wait", 64'(out_q.size() != 0), 64'd1);
   endtask

   task automatic check_first_fire(input string tag, input logic [AW-1:0] addr);
      if (fire_log.size() == 0) check(tag, 64'hdead, 64'(addr));
      else check(tag, 64'(fire_log[0]), 64'(addr));
   endtask

   initial begin
      rst = 1'b1; req_ready = 1'b0; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      resp_valid = 1'b0; resp_data = '0; resp_err = 1'b0;
      mpc = RESET_PC; m_fetch = '0; m_stall = '0; mem_timer = 0;
      lat_min = 0; lat_max = 0; err_by_addr = 1'b0; err_addr = '0;
      rdy_pct = 100; inst_pct = 100; redir_pct = 0;

      // Sequential fetch after reset, with the first request one cycle after release.
      apply_reset(2);
      req_ready = 1'b1; inst_ready = 1'b1;
      tick();
      check("first_req_valid", 64'(req_valid), 64'd1);
      check("first_req_addr", 64'(req_addr), 64'(RESET_PC));
      repeat (14) tick();
      for (int i = 0; i < 3; i++) begin
         if (i < fire_log.size()) check("seq_addr", 64'(fire_log[i]), 64'(RESET_PC + 32'(4 * i)));
         else check("seq_addr", 64'hdead, 64'(RESET_PC + 32'(4 * i)));
      end

      // A stalled decode stage fills the buffer. One pop then lets exactly one more request through.
      apply_reset(2);
      req_ready = 1'b1; inst_ready = 1'b0;
      repeat (30) tick();
      check("full_fires", 64'(fire_log.size()), 64'(DEPTH));
      check("full_req_idle", 64'(req_valid), 64'd0);
      inst_ready = 1'b1;
      tick();
      inst_ratio_hold: inst_ready = 1'b0;
      repeat (20) tick();
      check("pop_one_fire", 64'(fire_log.size()), 64'(DEPTH + 1));

      // Redirect while waiting: the stale response is dropped, and fetch resumes at the target.
      apply_reset(2);
      lat_min = 3; lat_max = 3;
      req_ready = 1'b1; inst_ready = 1'b1;
      run_until_outstanding(10);
      check("wait_state", 64'(dbg_state), 64'd2);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
      tick();
      check("drop_state", 64'(dbg_state), 64'd3);
      fire_log.delete();
      repeat (20) tick();
      check_first_fire("redir_wait_addr", 32'h8000_1000);

      // Redirect in the same cycle that a request is accepted.
      apply_reset(2);
      lat_min = 1; lat_max = 1;
      req_ready = 1'b0; inst_ready = 1'b1;
      for (int i = 0; i < 5 && !req_valid; i++) tick();
      check("req_pending", 64'(req_valid), 64'd1);
      req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_2002;
      tick();
      check("coincide_drop", 64'(dbg_state), 64'd3);
      fire_log.delete();
      repeat (20) tick();
      check_first_fire("redir_acc_addr", 32'h8000_2002);

      // A response error stays attached to its pc, and fetching continues.
      apply_reset(2);
      lat_min = 0; lat_max = 0;
      err_by_addr = 1'b1; err_addr = 32'h8000_0004;
      req_ready = 1'b1; inst_ready = 1'b1;
      repeat (20) tick();
      begin
         int idx;
         idx = -1;
         foreach (pop_log[i]) if (idx < 0 && pop_log[i][IW+AW-1:IW] == 32'h8000_0004) idx = i;
         check("err_seen", 64'(idx >= 0), 64'd1);
         if (idx >= 0) begin
            check("err_flag", 64'(pop_log[idx][EW-1]), 64'd1);
            if (idx + 1 < pop_log.size()) begin
               check("err_next_pc", 64'(pop_log[idx+1][IW+AW-1:IW]), 64'h8000_0008);
               check("err_next_flag", 64'(pop_log[idx+1][EW-1]), 64'd0);
            end else begin
               check("err_next_pc", 64'hdead, 64'h8000_0008);
            end
         end
      end
      err_by_addr = 1'b0;

      // Reset while waiting: the response still in flight must be discarded.
      apply_reset(2);
      lat_min = 4; lat_max = 4;
      req_ready = 1'b1; inst_ready = 1'b1;
      run_until_outstanding(10);
      apply_reset(1);
      req_ready = 1'b1; inst_ready = 1'b1;
      lat_min = 0; lat_max = 0;
      repeat (20) tick();
      check_first_fire("rst_wait_addr", RESET_PC);
      check("rst_wait_pop_pc", 64'(pop_log.size() != 0 ? pop_log[0][IW+AW-1:IW] : 32'h0), 64'(RESET_PC));

`ifdef IFU_PREFETCH_PERF_EN
      // Starved cycles, then a run of fetches.
      apply_reset(2);
      req_ready = 1'b0; inst_ready = 1'b1;
      repeat (3) tick();
      check("stall_three", 64'(stall_cnt), 64'd3);
      req_ready = 1'b1;
      for (int i = 0; i < 100 && m_fetch < 10; i++) tick();
      check("fetch_ten", 64'(fetch_cnt), 64'd10);
`endif

      // Random traffic, with random redirects (including unaligned targets) and occasional resets.
      rdy_pct = 70; inst_pct = 60; redir_pct = 5;
      for (int seg = 0; seg < 4; seg++) begin
         int pops_seen;
         apply_reset(2);
         lat_min = 0; lat_max = seg;
         pops_seen = 0;
         for (int c = 0; c < 700; c++) begin
            drive_random();
            if ($urandom_range(499, 0) == 0) begin
               pops_seen += pop_log.size();
               apply_reset(1 + $urandom_range(1, 0));
               drive_random();
            end
            tick();
         end
         pops_seen += pop_log.size();
         check("rand_progress", 64'(pops_seen > 0), 64'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
